// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter merging NREQ producers into one FIFO write port, plus read-side pointer/occupancy control.
// Latency: request sampled at edge k -> gnt/wr_en (and rd_en) registered, high for exactly one cycle after edge k.
// Backpressure: writes stall while full or flushing, reads stall while empty or flushing; unserved requests are re-arbitrated next cycle.
module fifo_wr_arbiter #(
    parameter int n    = 3,
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] wdata,
    input  logic              read,
    input  logic              flush,
    output logic [NREQ-1:0]   gnt,
    output logic              wr_en,
    output logic [n-1:0]      wr_addr,
    output logic [W-1:0]      wr_data,
    output logic              rd_en,
    output logic [n-1:0]      rd_addr,
    output logic [n:0]        count,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << n;
    localparam int LW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            wr_en_q, wr_en_d;
    logic [n-1:0]    wr_addr_q, wr_addr_d;
    logic [W-1:0]    wr_data_q, wr_data_d;
    logic            rd_en_q, rd_en_d;
    logic [n-1:0]    rd_addr_q, rd_addr_d;
    logic [n-1:0]    wr_ptr_q, wr_ptr_d;
    logic [n-1:0]    rd_ptr_q, rd_ptr_d;
    logic [n:0]      count_q, count_d;
    logic [LW-1:0]   last_q, last_d;

    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic            wr_acc;
    logic            rd_acc;

    // Flags come only from the registered occupancy, never from this cycle's accepts.
    assign full  = (count_q == (n+1)'(DEPTH));
    assign empty = (count_q == '0);

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign count   = count_q;

    // Round-robin search starting just after the last winner; a producer granted this cycle sits out.
    always_comb begin
        int idx;
        idx       = 0;
        elig      = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = LW'(idx);
            end
        end
    end

    assign wr_acc = win_found && !full  && !flush;
    assign rd_acc = read      && !empty && !flush;

    // Next-state: strobes default low, addresses/data hold; flush clears pointers and occupancy but keeps fairness state.
    always_comb begin
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        last_d    = last_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                gnt_d     = NREQ'(1) << win_idx;
                wr_en_d   = 1'b1;
                wr_addr_d = wr_ptr_q;
                wr_data_d = wdata[int'(win_idx)*W +: W];
                wr_ptr_d  = wr_ptr_q + n'(1);
                last_d    = win_idx;
            end
            if (rd_acc) begin
                rd_en_d   = 1'b1;
                rd_addr_d = rd_ptr_q;
                rd_ptr_d  = rd_ptr_q + n'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (n+1)'(1);
                2'b01:   count_d = count_q - (n+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset drops any in-flight grant and points fairness at producer 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_q    <= LW'(NREQ - 1);
        end else begin
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose: directed self-checking bench for fifo_wr_arbiter with default parameters (n=3, NREQ=4, W=8).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next one.
// Backpressure: full/empty blocking, masking of the previous winner and flush exercised explicitly.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        read;
    logic        flush;
    logic [3:0]  gnt;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int ntests = 0;
    int nfail  = 0;

    fifo_wr_arbiter #(.n(3), .NREQ(4), .W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wdata   (wdata),
        .read    (read),
        .flush   (flush),
        .gnt     (gnt),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_win [5] = '{0, 1, 2, 3, 0};

        rst = 1'b0; req = '0; wdata = '0; read = 1'b0; flush = 1'b0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_gnt",   gnt,   0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);

        // First accept on first edge after reset release
        rst = 1'b1; req = 4'b0001; wdata = 32'h0000_0011;
        tick();
        chk("first_gnt",     gnt,     4'b0001);
        chk("first_wr_en",   wr_en,   1);
        chk("first_wr_addr", wr_addr, 0);
        chk("first_wr_data", wr_data, 8'h11);
        chk("first_count",   count,   1);
        chk("first_empty",   empty,   0);
        req = 4'b0000;
        tick();
        chk("idle_gnt",     gnt,     0);
        chk("idle_wr_en",   wr_en,   0);
        chk("idle_wr_data", wr_data, 8'h11);
        chk("idle_count",   count,   1);

        // Single held requester: granted, masked, granted
        req = 4'b0001; wdata = 32'h0000_0022;
        tick();
        chk("mask1_gnt",     gnt,     4'b0001);
        chk("mask1_wr_addr", wr_addr, 1);
        chk("mask1_count",   count,   2);
        tick();
        chk("mask2_gnt",   gnt,   0);
        chk("mask2_wr_en", wr_en, 0);
        chk("mask2_count", count, 2);
        tick();
        chk("mask3_gnt",     gnt,     4'b0001);
        chk("mask3_wr_addr", wr_addr, 2);
        chk("mask3_count",   count,   3);
        req = 4'b0000;
        tick();

        // Flush dominates a concurrent write and read
        flush = 1'b1; req = 4'b0001; read = 1'b1;
        tick();
        chk("flush_count", count, 0);
        chk("flush_wr_en", wr_en, 0);
        chk("flush_rd_en", rd_en, 0);
        chk("flush_gnt",   gnt,   0);
        chk("flush_empty", empty, 1);
        flush = 1'b0; read = 1'b0; wdata = 32'h0000_0033;
        tick();
        chk("postflush_wr_en",   wr_en,   1);
        chk("postflush_wr_addr", wr_addr, 0);
        chk("postflush_count",   count,   1);
        req = 4'b0000; read = 1'b1;
        tick();
        chk("rd0_rd_en",   rd_en,   1);
        chk("rd0_rd_addr", rd_addr, 0);
        chk("rd0_count",   count,   0);

        // Empty with write pending: write goes, read blocked
        req = 4'b0001; wdata = 32'h0000_0044;
        tick();
        chk("emptyblk_wr_en",   wr_en,   1);
        chk("emptyblk_wr_addr", wr_addr, 1);
        chk("emptyblk_rd_en",   rd_en,   0);
        chk("emptyblk_count",   count,   1);
        req = 4'b0000; read = 1'b0;
        tick();

        // Simultaneous write and read: count unchanged
        req = 4'b0001; wdata = 32'h0000_0055; read = 1'b1;
        tick();
        chk("both_wr_en",   wr_en,   1);
        chk("both_wr_addr", wr_addr, 2);
        chk("both_rd_en",   rd_en,   1);
        chk("both_rd_addr", rd_addr, 1);
        chk("both_count",   count,   1);
        req = 4'b0000;
        tick();
        chk("drain_rd_addr", rd_addr, 2);
        chk("drain_count",   count,   0);
        tick();
        chk("rdempty_rd_en",   rd_en,   0);
        chk("rdempty_rd_addr", rd_addr, 2);
        chk("rdempty_count",   count,   0);
        read = 1'b0;

        // Fresh reset, then round robin with all four requesting every cycle
        #2 rst = 1'b0;
        #3 rst = 1'b1;
        req = 4'b1111; wdata = 32'h4342_4140;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt",     gnt,     32'd1 << exp_win[i]);
            chk("rr_wr_data", wr_data, 32'h40 + exp_win[i]);
            chk("rr_wr_addr", wr_addr, i);
            chk("rr_count",   count,   i + 1);
        end

        // Asynchronous reset between edges with count=5
        #2 rst = 1'b0;
        #1;
        chk("arst_count",   count,   0);
        chk("arst_empty",   empty,   1);
        chk("arst_gnt",     gnt,     0);
        chk("arst_wr_en",   wr_en,   0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_wr_data", wr_data, 0);
        req = 4'b0000;
        #2 rst = 1'b1;
        tick();
        chk("postrst_wr_en", wr_en, 0);
        chk("postrst_gnt",   gnt,   0);
        chk("postrst_count", count, 0);

        // Producer 1 fills the FIFO with A0..A7
        req = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            wdata = (32'hA0 + i) << 8;
            tick();
            chk("fill_gnt",     gnt,     4'b0010);
            chk("fill_wr_addr", wr_addr, i);
            chk("fill_wr_data", wr_data, 32'hA0 + i);
            chk("fill_count",   count,   i + 1);
            tick();
            chk("fill_mask_wr_en", wr_en, 0);
        end
        chk("fill_full", full, 1);
        tick();
        chk("fullblk_gnt",   gnt,   0);
        chk("fullblk_wr_en", wr_en, 0);
        chk("fullblk_count", count, 8);
        chk("fullblk_full",  full,  1);

        // At full: read wins, write blocked, then write lands at wrapped address 0
        req = 4'b0100; wdata = 32'h005C_0000; read = 1'b1;
        tick();
        chk("fullrd_rd_en",   rd_en,   1);
        chk("fullrd_rd_addr", rd_addr, 0);
        chk("fullrd_wr_en",   wr_en,   0);
        chk("fullrd_gnt",     gnt,     0);
        chk("fullrd_count",   count,   7);
        read = 1'b0;
        tick();
        chk("fullwr_wr_en",   wr_en,   1);
        chk("fullwr_gnt",     gnt,     4'b0100);
        chk("fullwr_wr_addr", wr_addr, 0);
        chk("fullwr_wr_data", wr_data, 8'h5C);
        chk("fullwr_count",   count,   8);
        req = 4'b0000;

        // Pointer wrap: ten alternating write/read pairs from empty
        flush = 1'b1;
        tick();
        chk("wrap_flush_count", count, 0);
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req = 4'b0001; wdata = 32'h60 + i;
            tick();
            chk("wrap_wr_en",   wr_en,   1);
            chk("wrap_wr_addr", wr_addr, i % 8);
            chk("wrap_wcount",  count,   1);
            req = 4'b0000; read = 1'b1;
            tick();
            chk("wrap_rd_en",   rd_en,   1);
            chk("wrap_rd_addr", rd_addr, i % 8);
            chk("wrap_rcount",  count,   0);
            read = 1'b0;
        end
        chk("wrap_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
